// File: rtl/gonogo_pkg.sv
// Shared encodings for the GO/NOGO step sequencer: FSM states, output levels
// and the time-unit convention used by the step table.
package gonogo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic GO       = 1'b1;
    localparam logic NOGO     = 1'b0;
    localparam logic UNIT_SEC = 1'b1;
    localparam logic UNIT_MIN = 1'b0;

    // Picks the timebase tick matching a step's unit; the other tick is ignored.
    function automatic logic sel_tick(input logic unit, input logic t_sec, input logic t_min);
        logic t_s;
        if (unit == UNIT_SEC) begin
            t_s = t_sec;
        end else begin
            t_s = t_min;
        end
        return t_s;
    endfunction

endpackage

// File: rtl/gonogo_step_table.sv
// Step table register file: DEPTH entries of {level, unit, duration}, one write
// port, combinational read, cleared by asynchronous reset.
module gonogo_step_table
    import gonogo_pkg::*;
#(
    parameter int NBITS = 12,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [NBITS-1:0] wdur,
    input  logic             wunit,
    input  logic             wlevel,
    input  logic [AW-1:0]    raddr,
    output logic [NBITS-1:0] rdur,
    output logic             runit,
    output logic             rlevel
);

    localparam logic [NBITS+1:0] ENTRY_RST = {NOGO, UNIT_MIN, {NBITS{1'b0}}};

    logic [NBITS+1:0] mem_q [DEPTH];
    logic [NBITS+1:0] mem_d [DEPTH];

    // Next-state of the table: single write port
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = {wlevel, wunit, wdur};
        end else begin
            mem_d[waddr] = mem_q[waddr];
        end
    end

    // Table storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= ENTRY_RST;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rlevel = mem_q[raddr][NBITS+1];
    assign runit  = mem_q[raddr][NBITS];
    assign rdur   = mem_q[raddr][NBITS-1:0];

endmodule

// File: rtl/gonogo_sequencer.sv
// Programmable GO/NOGO scheduler: walks a table of timed steps driven by the
// second/minute timebase ticks, with start/stop/pause/loop run control.
module gonogo_sequencer
    import gonogo_pkg::*;
#(
    parameter int   NBITS      = 12,
    parameter int   DEPTH      = 8,
    parameter int   AW         = 3,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_sec,
    input  logic             tick_min,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [NBITS-1:0] cfg_dur,
    input  logic             cfg_unit,
    input  logic             cfg_level,
    input  logic [AW-1:0]    last_step,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             loop,
    output logic             gonogo,
    output logic [AW-1:0]    step_idx,
    output logic [NBITS-1:0] remaining,
    output logic             busy,
    output logic             done
);

    localparam logic [NBITS-1:0] REM_ONE = {{(NBITS-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]    IDX_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW-1:0]    last_q, last_d;
    logic             pass_nz_q, pass_nz_d;
    logic [NBITS-1:0] rem_q, rem_d;
    logic             gonogo_q, gonogo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             we_s;
    logic             advance_s;
    logic [NBITS-1:0] step_dur_s;
    logic             step_unit_s;
    logic             step_level_s;

    assign we_s = cfg_we && ((state_q == IDLE) || (state_q == DONE));

    gonogo_step_table #(
        .NBITS (NBITS),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .clk    (clk),
        .rst    (rst),
        .we     (we_s),
        .waddr  (cfg_addr),
        .wdur   (cfg_dur),
        .wunit  (cfg_unit),
        .wlevel (cfg_level),
        .raddr  (idx_q),
        .rdur   (step_dur_s),
        .runit  (step_unit_s),
        .rlevel (step_level_s)
    );

    // Next-state, countdown and output computation
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        pass_nz_d = pass_nz_q;
        rem_d     = rem_q;
        gonogo_d  = gonogo_q;
        done_d    = 1'b0;
        advance_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d   = LOAD;
                    idx_d     = {AW{1'b0}};
                    last_d    = last_step;
                    pass_nz_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (step_dur_s == {NBITS{1'b0}}) begin
                    advance_s = 1'b1;
                end else begin
                    rem_d     = step_dur_s;
                    gonogo_d  = step_level_s;
                    pass_nz_d = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (!pause && sel_tick(step_unit_s, tick_sec, tick_min)) begin
                    if (rem_q > REM_ONE) begin
                        rem_d = rem_q - REM_ONE;
                    end else begin
                        rem_d     = {NBITS{1'b0}};
                        advance_s = 1'b1;
                    end
                end else begin
                    rem_d = rem_q;
                end
            end
            DONE: begin
                state_d  = IDLE;
                done_d   = 1'b1;
                gonogo_d = IDLE_LEVEL;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Advance covers both a skipped zero-length step and an expired one
        if (advance_s) begin
            if (idx_q != last_q) begin
                idx_d   = idx_q + IDX_ONE;
                state_d = LOAD;
            end else if (loop && pass_nz_q) begin
                idx_d     = {AW{1'b0}};
                pass_nz_d = 1'b0;
                state_d   = LOAD;
            end else begin
                state_d = DONE;
            end
        end else begin
            idx_d = idx_d;
        end

        if (stop && (state_q != IDLE)) begin
            state_d   = IDLE;
            idx_d     = idx_q;
            pass_nz_d = pass_nz_q;
            gonogo_d  = IDLE_LEVEL;
            rem_d     = {NBITS{1'b0}};
            done_d    = 1'b0;
        end else begin
            done_d = done_d;
        end

        busy_d = (state_d == LOAD) || (state_d == RUN);
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= {AW{1'b0}};
            last_q    <= {AW{1'b0}};
            pass_nz_q <= 1'b0;
            rem_q     <= {NBITS{1'b0}};
            gonogo_q  <= IDLE_LEVEL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            pass_nz_q <= pass_nz_d;
            rem_q     <= rem_d;
            gonogo_q  <= gonogo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign gonogo    = gonogo_q;
    assign step_idx  = idx_q;
    assign remaining = rem_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_gonogo_sequencer.sv
// Self-checking bench for gonogo_sequencer: per-cycle vectors whose expected
// outputs go through a scoreboard queue, plus multi-cycle corner sequences.
module tb_gonogo_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_sec = 1'b0, tick_min = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = 3'd0;
    logic [11:0] cfg_dur = 12'd0;
    logic        cfg_unit = 1'b0, cfg_level = 1'b0;
    logic [2:0]  last_step = 3'd0;
    logic        start = 1'b0, stop = 1'b0, pause = 1'b0, loop = 1'b0;
    logic        gonogo, busy, done;
    logic [2:0]  step_idx;
    logic [11:0] remaining;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        ts, tm, st, sp, pa;
        logic        g, b, d;
        logic [2:0]  idx;
        logic [11:0] rem;
    } vec_t;

    vec_t exp_q[$];
    vec_t t1[13];

    gonogo_sequencer dut (
        .clk(clk), .rst(rst), .tick_sec(tick_sec), .tick_min(tick_min),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_dur(cfg_dur),
        .cfg_unit(cfg_unit), .cfg_level(cfg_level), .last_step(last_step),
        .start(start), .stop(stop), .pause(pause), .loop(loop),
        .gonogo(gonogo), .step_idx(step_idx), .remaining(remaining),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic ts, tm, st, sp, pa, g, b, d,
                                input logic [2:0] idx, input logic [11:0] rem);
        vec_t v;
        v.ts = ts; v.tm = tm; v.st = st; v.sp = sp; v.pa = pa;
        v.g = g; v.b = b; v.d = d; v.idx = idx; v.rem = rem;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(input string nm, input vec_t v);
        vec_t e;
        @(negedge clk);
        tick_sec = v.ts; tick_min = v.tm; start = v.st; stop = v.sp; pause = v.pa;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({nm, ".gonogo"}, {31'd0, gonogo}, {31'd0, e.g});
        check({nm, ".busy"}, {31'd0, busy}, {31'd0, e.b});
        check({nm, ".done"}, {31'd0, done}, {31'd0, e.d});
        check({nm, ".step_idx"}, {29'd0, step_idx}, {29'd0, e.idx});
        check({nm, ".remaining"}, {20'd0, remaining}, {20'd0, e.rem});
        tick_sec = 1'b0; tick_min = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [11:0] dur, input logic unit, input logic lvl);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_dur = dur; cfg_unit = unit; cfg_level = lvl;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Two-step one-shot: GO 3 s then NOGO 2 s
        t1[0]  = mk(0,0,1,0,0, 1,1,0, 3'd0, 12'd0);
        t1[1]  = mk(0,0,0,0,0, 1,1,0, 3'd0, 12'd3);
        t1[2]  = mk(1,0,0,0,0, 1,1,0, 3'd0, 12'd2);
        t1[3]  = mk(0,0,0,0,0, 1,1,0, 3'd0, 12'd2);
        t1[4]  = mk(1,0,0,0,0, 1,1,0, 3'd0, 12'd1);
        t1[5]  = mk(0,0,0,0,0, 1,1,0, 3'd0, 12'd1);
        t1[6]  = mk(1,0,0,0,0, 1,1,0, 3'd1, 12'd0);
        t1[7]  = mk(0,0,0,0,0, 0,1,0, 3'd1, 12'd2);
        t1[8]  = mk(1,0,0,0,0, 0,1,0, 3'd1, 12'd1);
        t1[9]  = mk(0,0,0,0,0, 0,1,0, 3'd1, 12'd1);
        t1[10] = mk(1,0,0,0,0, 0,0,0, 3'd1, 12'd0);
        t1[11] = mk(0,0,0,0,0, 1,0,1, 3'd1, 12'd0);
        t1[12] = mk(0,0,0,0,0, 1,0,0, 3'd1, 12'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        apply("reset", mk(0,0,0,0,0, 1,0,0, 3'd0, 12'd0));

        wr(3'd0, 12'd3, 1'b1, 1'b1);
        wr(3'd1, 12'd2, 1'b1, 1'b0);
        last_step = 3'd1; loop = 1'b0;
        for (int i = 0; i < 13; i++) apply("oneshot", t1[i]);

        // Same table looping: pattern 1,1,1,0,0 twice, never done
        loop = 1'b1;
        apply("loop_start", mk(0,0,1,0,0, 1,1,0, 3'd0, 12'd0));
        apply("loop_run",   mk(0,0,0,0,0, 1,1,0, 3'd0, 12'd3));
        for (int p = 0; p < 2; p++) begin
            apply("loop_t1", mk(1,0,0,0,0, 1,1,0, 3'd0, 12'd2));
            apply("loop_t2", mk(1,0,0,0,0, 1,1,0, 3'd0, 12'd1));
            apply("loop_t3", mk(1,0,0,0,0, 1,1,0, 3'd1, 12'd0));
            apply("loop_l1", mk(0,0,0,0,0, 0,1,0, 3'd1, 12'd2));
            apply("loop_t4", mk(1,0,0,0,0, 0,1,0, 3'd1, 12'd1));
            apply("loop_t5", mk(1,0,0,0,0, 0,1,0, 3'd0, 12'd0));
            apply("loop_l0", mk(0,0,0,0,0, 1,1,0, 3'd0, 12'd3));
        end
        apply("loop_stop", mk(0,0,0,1,0, 1,0,0, 3'd0, 12'd0));
        loop = 1'b0;

        // Minute step ignores second ticks; coincident ticks count once
        wr(3'd0, 12'd2, 1'b0, 1'b0);
        last_step = 3'd0;
        apply("min_start", mk(0,0,1,0,0, 1,1,0, 3'd0, 12'd0));
        apply("min_run",   mk(0,0,0,0,0, 0,1,0, 3'd0, 12'd2));
        for (int i = 0; i < 120; i++) apply("min_sec", mk(1,0,0,0,0, 0,1,0, 3'd0, 12'd2));
        apply("min_tick",  mk(0,1,0,0,0, 0,1,0, 3'd0, 12'd1));
        apply("min_both",  mk(1,1,0,0,0, 0,0,0, 3'd0, 12'd0));
        apply("min_done",  mk(0,0,0,0,0, 1,0,1, 3'd0, 12'd0));

        // Zero-length step is skipped in one LOAD cycle
        wr(3'd0, 12'd0, 1'b1, 1'b1);
        wr(3'd1, 12'd1, 1'b1, 1'b0);
        last_step = 3'd1;
        apply("skip_start", mk(0,0,1,0,0, 1,1,0, 3'd0, 12'd0));
        apply("skip_load0", mk(0,0,0,0,0, 1,1,0, 3'd1, 12'd0));
        apply("skip_load1", mk(0,0,0,0,0, 0,1,0, 3'd1, 12'd1));
        apply("skip_tick",  mk(1,0,0,0,0, 0,0,0, 3'd1, 12'd0));
        apply("skip_done",  mk(0,0,0,0,0, 1,0,1, 3'd1, 12'd0));

        // All-zero table in loop mode ends after one pass
        wr(3'd1, 12'd0, 1'b1, 1'b0);
        loop = 1'b1;
        apply("zero_start", mk(0,0,1,0,0, 1,1,0, 3'd0, 12'd0));
        apply("zero_load0", mk(0,0,0,0,0, 1,1,0, 3'd1, 12'd0));
        apply("zero_load1", mk(0,0,0,0,0, 1,0,0, 3'd1, 12'd0));
        apply("zero_done",  mk(0,0,0,0,0, 1,0,1, 3'd1, 12'd0));
        loop = 1'b0;

        // Pause drops ticks; stop with a tick aborts without done
        wr(3'd0, 12'd4, 1'b1, 1'b0);
        last_step = 3'd0;
        apply("pause_start", mk(0,0,1,0,0, 1,1,0, 3'd0, 12'd0));
        apply("pause_run",   mk(0,0,0,0,0, 0,1,0, 3'd0, 12'd4));
        for (int i = 0; i < 3; i++) apply("pause_hold", mk(1,0,0,0,1, 0,1,0, 3'd0, 12'd4));
        apply("pause_rel",   mk(1,0,0,0,0, 0,1,0, 3'd0, 12'd3));
        apply("pause_stop",  mk(1,0,0,1,0, 1,0,0, 3'd0, 12'd0));
        apply("pause_after", mk(0,0,0,0,0, 1,0,0, 3'd0, 12'd0));

        // Full-scale duration
        wr(3'd0, 12'd4095, 1'b1, 1'b1);
        apply("max_start", mk(0,0,1,0,0, 1,1,0, 3'd0, 12'd0));
        apply("max_run",   mk(0,0,0,0,0, 1,1,0, 3'd0, 12'd4095));
        apply("max_tick",  mk(1,0,0,0,0, 1,1,0, 3'd0, 12'd4094));
        apply("max_busy",  mk(0,0,1,0,0, 1,1,0, 3'd0, 12'd4094));
        apply("max_stop",  mk(0,0,0,1,0, 1,0,0, 3'd0, 12'd0));

        // Asynchronous reset mid-RUN
        wr(3'd0, 12'd3, 1'b1, 1'b0);
        apply("rst_start", mk(0,0,1,0,0, 1,1,0, 3'd0, 12'd0));
        apply("rst_run",   mk(0,0,0,0,0, 0,1,0, 3'd0, 12'd3));
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async.gonogo", {31'd0, gonogo}, 32'd1);
        check("rst_async.busy", {31'd0, busy}, 32'd0);
        check("rst_async.remaining", {20'd0, remaining}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        apply("clr_start", mk(0,0,1,0,0, 1,1,0, 3'd0, 12'd0));
        apply("clr_skip",  mk(0,0,0,0,0, 1,0,0, 3'd0, 12'd0));
        apply("clr_done",  mk(0,0,0,0,0, 1,0,1, 3'd0, 12'd0));

        // Writes while running are ignored
        wr(3'd0, 12'd2, 1'b1, 1'b0);
        apply("wrun_start", mk(0,0,1,0,0, 1,1,0, 3'd0, 12'd0));
        apply("wrun_run",   mk(0,0,0,0,0, 0,1,0, 3'd0, 12'd2));
        wr(3'd0, 12'd5, 1'b1, 1'b1);
        apply("wrun_hold",  mk(0,0,0,0,0, 0,1,0, 3'd0, 12'd2));
        apply("wrun_t1",    mk(1,0,0,0,0, 0,1,0, 3'd0, 12'd1));
        apply("wrun_t2",    mk(1,0,0,0,0, 0,0,0, 3'd0, 12'd0));
        apply("wrun_done",  mk(0,0,0,0,0, 1,0,1, 3'd0, 12'd0));
        apply("wrun_again", mk(0,0,1,0,0, 1,1,0, 3'd0, 12'd0));
        apply("wrun_reld",  mk(0,0,0,0,0, 0,1,0, 3'd0, 12'd2));
        apply("wrun_stop",  mk(0,0,0,1,0, 1,0,0, 3'd0, 12'd0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
